// File: rtl/vote_rx_stage_if.sv
// Voter-to-host bundle: four-phase RTR/CTS vote input plus the host-side FIFO read and stats view.
interface vote_rx_stage_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          CTS;
    logic [3:0]    V_OUT;
    logic          RTR;
    logic          RD_EN;
    logic [3:0]    RD_DATA;
    logic          EMPTY;
    logic          FULL;
    logic [CW-1:0] COUNT;
    logic [7:0]    WORDS;
    logic          ERR;
    logic          CLR_STATS;

    modport master (
        output CTS, V_OUT, RD_EN, CLR_STATS,
        input  RTR, RD_DATA, EMPTY, FULL, COUNT, WORDS, ERR
    );

    modport slave (
        input  CTS, V_OUT, RD_EN, CLR_STATS,
        output RTR, RD_DATA, EMPTY, FULL, COUNT, WORDS, ERR
    );
endinterface

// File: rtl/vote_rx_stage.sv
// Receive stage for the voter: four-phase RTR/CTS capture into a show-ahead FIFO, word count, timeout flag.
// Word visible one cycle after capture; RTR withheld while FULL, so the voter stalls instead of overflowing.
module vote_rx_stage #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    vote_rx_stage_if.slave  bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_READY   = 2'b01,
        S_RELEASE = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_tmo;
    logic [7:0]      w_tmo_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_tmo_hit;

    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_rd_ptr_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [3:0]      w_head_nxt;

    logic            r_rtr;
    logic            r_empty;
    logic            r_full;
    logic [3:0]      r_rd_data;
    logic [7:0]      r_words;
    logic            r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_push      = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A strobe still high here belongs to a word already taken or abandoned.
                if (!bus.CTS && !r_full) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (bus.CTS) begin
                    w_push      = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bus.CTS) begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt   = r_tmo + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_pop        = bus.RD_EN && !r_empty;
        w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_count_nxt  = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        // The new head is the word being written when the read pointer lands on the write slot.
        if (w_count_nxt == '0) begin
            w_head_nxt = 4'h0;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = bus.V_OUT;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_tmo     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rtr     <= 1'b0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_rd_data <= 4'h0;
            r_words   <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo     <= w_tmo_nxt;
            r_rtr     <= (w_state_nxt == S_READY);
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == CW'(DEPTH));
            r_rd_data <= w_head_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (bus.CLR_STATS) begin
                r_words <= 8'h00;
                r_err   <= 1'b0;
            end else begin
                if (w_push && (r_words != 8'hFF)) begin
                    r_words <= r_words + 8'd1;
                end
                if (w_tmo_hit) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.V_OUT;
        end
    end

    assign bus.RTR     = r_rtr;
    assign bus.RD_DATA = r_rd_data;
    assign bus.EMPTY   = r_empty;
    assign bus.FULL    = r_full;
    assign bus.COUNT   = r_count;
    assign bus.WORDS   = r_words;
    assign bus.ERR     = r_err;
endmodule
